// File: rtl/ntt_pkg.sv
// Shared encodings and helpers for the flat NTT sequencer slice.
package ntt_pkg;

    localparam logic [1:0] ST_LOAD  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    localparam logic MODE_NTT  = 1'b0;
    localparam logic MODE_INTT = 1'b1;

    typedef enum logic [1:0] {
        S_LOAD  = ST_LOAD,
        S_RUN   = ST_RUN,
        S_DRAIN = ST_DRAIN
    } seq_state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/ntt_flat_seq_if.sv
// Serial coefficient streams in and out of the flat NTT sequencer.
interface ntt_flat_seq_if #(parameter int N = 17);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_data;
    logic         in_mode;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_data;
    logic         out_last;

    modport master (output in_valid, in_data, in_mode, out_ready,
                    input  in_ready, out_valid, out_data, out_last);
    modport slave  (input  in_valid, in_data, in_mode, out_ready,
                    output in_ready, out_valid, out_data, out_last);
endinterface

// File: rtl/ntt_flat_slot_mux.sv
// D-way read mux selecting one N-bit word out of a flat D*N bus.
module ntt_flat_slot_mux #(
    parameter int N  = 17,
    parameter int D  = 16,
    parameter int SW = 4
) (
    input  logic [D*N-1:0] bus,
    input  logic [SW-1:0]  sel,
    output logic [N-1:0]   dout
);
    logic [N-1:0] words [D];

    for (genvar k = 0; k < D; k++) begin : g_slot
        assign words[k] = bus[k*N +: N];
    end

    assign dout = words[sel];
endmodule

// File: rtl/ntt_flat_seq.sv
// Serial-to-flat loader, fixed-latency wait and flat-to-serial drain around
// the flat NTT datapath. One frame in flight at a time.
module ntt_flat_seq
    import ntt_pkg::*;
#(
    parameter int N   = 17,
    parameter int D   = 16,
    parameter int LAT = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    ntt_flat_seq_if.slave  s,
    output logic           busy,
    output logic [D*N-1:0] dp_a,
    output logic           dp_mode,
    input  logic [D*N-1:0] dp_b
);
    localparam int CW = clog2(D);
    localparam int WW = (LAT > 1) ? clog2(LAT) : 1;

    seq_state_t     state, state_nxt;
    logic [CW-1:0]  cnt;
    logic [WW-1:0]  wcnt;
    logic [D*N-1:0] res;
    logic           in_fire, out_fire, cnt_last;

    assign cnt_last = (cnt == CW'(D-1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_LOAD;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        s.in_ready  = 1'b0;
        s.out_valid = 1'b0;
        s.out_last  = 1'b0;
        in_fire     = 1'b0;
        out_fire    = 1'b0;
        case (state)
            S_LOAD: begin
                s.in_ready = 1'b1;
                in_fire    = s.in_valid;
                if (in_fire && cnt_last) state_nxt = S_RUN;
            end
            S_RUN: begin
                if (wcnt == '0) state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                s.out_valid = 1'b1;
                s.out_last  = cnt_last;
                out_fire    = s.out_ready;
                if (out_fire && cnt_last) state_nxt = S_LOAD;
            end
            default: state_nxt = S_LOAD;
        endcase
    end

    // cnt is shared: word slot while loading, result slot while draining.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            wcnt    <= '0;
            dp_a    <= '0;
            dp_mode <= MODE_NTT;
            res     <= '0;
        end else begin
            if (in_fire) begin
                dp_a[cnt*N +: N] <= s.in_data;
                if (cnt == '0) dp_mode <= s.in_mode;
                if (cnt_last)  wcnt    <= WW'(LAT-1);
                cnt <= cnt + CW'(1);
            end
            if (state == S_RUN) begin
                if (wcnt == '0) res  <= dp_b;
                else            wcnt <= wcnt - WW'(1);
            end
            if (out_fire) cnt <= cnt + CW'(1);
        end
    end

    assign busy = !(state == S_LOAD && cnt == '0);

    ntt_flat_slot_mux #(.N(N), .D(D), .SW(CW)) u_mux (
        .bus  (res),
        .sel  (cnt),
        .dout (s.out_data)
    );
endmodule
